// File: rtl/formula_1_arg_dispatcher.sv
// formula_1_arg_dispatcher
//
// Feeds (a, b, c) triples to the formula-1 unit, which computes
// isqrt(a)+isqrt(b)+isqrt(c). The unit only accepts an argument while it is
// idle and has no ready output, so this block issues one triple at a time
// and waits for the result before issuing the next one.
//
// Ports:
//   clk, rst            clock (posedge) and synchronous active-low reset
//   up_vld, up_rdy      upstream handshake for one triple
//   a, b, c             upstream operands (32 bits each)
//   fu_arg_vld          one-cycle argument strobe to the formula unit
//   fu_a, fu_b, fu_c    operands to the formula unit, held between issues
//   fu_res_vld, fu_res  result strobe and value from the formula unit
//   out_vld, out_res    one-cycle forwarded result strobe and value
//   out_idx             sequence index of the forwarded result (wraps at 255)
//   busy                high while a transaction is in flight or queued
//   err                 sticky protocol error (stray result or timeout)
module formula_1_arg_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_vld,
    output logic        up_rdy,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        fu_arg_vld,
    output logic [31:0] fu_a,
    output logic [31:0] fu_b,
    output logic [31:0] fu_c,
    input  logic        fu_res_vld,
    input  logic [31:0] fu_res,
    output logic        out_vld,
    output logic [31:0] out_res,
    output logic [7:0]  out_idx,
    output logic        busy,
    output logic        err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [95:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    idx_cnt;
    logic [95:0]   head;
    logic          push;
    logic          pop;

    // Handshake and FIFO control. up_rdy is gated by rst so nothing is
    // accepted while the block is held in reset. The head entry is only
    // consumed at the end of the single ISSUE cycle.
    always_comb begin
        up_rdy     = (count != FULL) && rst;
        push       = up_vld && up_rdy;
        pop        = (state == ISSUE);
        head       = mem[rd_ptr];
        fu_arg_vld = (state == ISSUE);
        busy       = (state != IDLE) || (count != '0);
    end

    // FIFO storage. Entries are not reset; only the pointers and count
    // decide what is valid, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {a, b, c};
        end
    end

    // Main control: FIFO pointers and count, the IDLE/ISSUE/WAIT sequencer,
    // the wait counter, result forwarding with its sequence index, and the
    // sticky error flag. A result arriving in the last WAIT cycle takes
    // priority over the timeout so it is forwarded normally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            state    <= IDLE;
            wait_cnt <= '0;
            idx_cnt  <= '0;
            fu_a     <= '0;
            fu_b     <= '0;
            fu_c     <= '0;
            out_vld  <= 1'b0;
            out_res  <= '0;
            out_idx  <= '0;
            err      <= 1'b0;
        end else begin
            out_vld <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (fu_res_vld) begin
                        err <= 1'b1;
                    end
                    if (count != '0) begin
                        state <= ISSUE;
                        fu_a  <= head[95:64];
                        fu_b  <= head[63:32];
                        fu_c  <= head[31:0];
                    end
                end
                ISSUE: begin
                    if (fu_res_vld) begin
                        err <= 1'b1;
                    end
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (fu_res_vld) begin
                        out_vld <= 1'b1;
                        out_res <= fu_res;
                        out_idx <= idx_cnt;
                        idx_cnt <= idx_cnt + 8'd1;
                        state   <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_formula_1_arg_dispatcher.sv
// tb_formula_1_arg_dispatcher
//
// Self-checking bench for formula_1_arg_dispatcher. A small formula-unit
// model answers each issued argument after a programmable delay; pushed
// triples go into a pending queue, and each issue moves the expected sum
// into a result queue that is compared when out_vld appears.
module tb_formula_1_arg_dispatcher;

    logic        clk;
    logic        rst;
    logic        up_vld;
    logic        up_rdy;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        fu_arg_vld;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic [31:0] fu_c;
    logic        fu_res_vld;
    logic [31:0] fu_res;
    logic        out_vld;
    logic [31:0] out_res;
    logic [7:0]  out_idx;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [95:0] pend [$];
    logic [31:0] exp_q [$];
    logic [7:0]  exp_idx = 8'd0;

    int          resp_mode  = 0;
    int          resp_delay = 3;
    bit          resp_hold  = 1'b0;

    int          out_count   = 0;
    int          issue_count = 0;
    logic [7:0]  h0 = 8'd0;
    logic [7:0]  h1 = 8'd0;
    logic [7:0]  h2 = 8'd0;
    logic [31:0] last_res = 32'd0;

    formula_1_arg_dispatcher #(
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_vld     (up_vld),
        .up_rdy     (up_rdy),
        .a          (a),
        .b          (b),
        .c          (c),
        .fu_arg_vld (fu_arg_vld),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_c       (fu_c),
        .fu_res_vld (fu_res_vld),
        .fu_res     (fu_res),
        .out_vld    (out_vld),
        .out_res    (out_res),
        .out_idx    (out_idx),
        .busy       (busy),
        .err        (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream of the bounded waits goes wrong.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] isqrt(input logic [31:0] x);
        logic [31:0] n;
        logic [31:0] r;
        logic [31:0] bv;
        n  = x;
        r  = 32'd0;
        bv = 32'h4000_0000;
        while (bv > n) bv = bv >> 2;
        while (bv != 32'd0) begin
            if (n >= r + bv) begin
                n = n - (r + bv);
                r = (r >> 1) + bv;
            end else begin
                r = r >> 1;
            end
            bv = bv >> 2;
        end
        return r;
    endfunction

    function automatic logic [31:0] formula(input logic [95:0] t);
        return isqrt(t[95:64]) + isqrt(t[63:32]) + isqrt(t[31:0]);
    endfunction

    // Formula-unit model: answers an issued argument resp_delay cycles after
    // fu_arg_vld, optionally stalled by resp_hold, and drops any pending
    // answer if reset is asserted meanwhile.
    initial begin
        logic [31:0] r;
        bit          aborted;
        fu_res_vld = 1'b0;
        fu_res     = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (fu_arg_vld && rst && resp_mode == 0) begin
                r       = isqrt(fu_a) + isqrt(fu_b) + isqrt(fu_c);
                aborted = 1'b0;
                for (int i = 1; i < resp_delay; i++) begin
                    @(posedge clk);
                    #1;
                    if (!rst) aborted = 1'b1;
                end
                while (resp_hold && !aborted) begin
                    @(posedge clk);
                    #1;
                    if (!rst) aborted = 1'b1;
                end
                @(posedge clk);
                #1;
                if (!rst) aborted = 1'b1;
                if (!aborted) begin
                    fu_res_vld = 1'b1;
                    fu_res     = r;
                    @(posedge clk);
                    #1;
                    fu_res_vld = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every issue must match the oldest pushed triple,
    // every forwarded result must match the oldest expected sum and index.
    initial begin
        logic [95:0] t;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (fu_arg_vld) begin
                issue_count++;
                checks++;
                if (pend.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL issue_unexpected: fu_a=%0d fu_b=%0d fu_c=%0d, required no issue",
                             fu_a, fu_b, fu_c);
                end else begin
                    t = pend.pop_front();
                    if ({fu_a, fu_b, fu_c} !== t) begin
                        errors++;
                        $display("[TB] FAIL issue_operands: got %0d/%0d/%0d, required %0d/%0d/%0d",
                                 fu_a, fu_b, fu_c, t[95:64], t[63:32], t[31:0]);
                    end
                    if (resp_mode == 0) exp_q.push_back(formula(t));
                end
            end
            if (out_vld) begin
                out_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL out_unexpected: out_res=%0d out_idx=%0d, required no output",
                             out_res, out_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (out_res !== e || out_idx !== exp_idx) begin
                        errors++;
                        $display("[TB] FAIL out_result: res=%0d idx=%0d, required res=%0d idx=%0d",
                                 out_res, out_idx, e, exp_idx);
                    end
                    exp_idx++;
                end
                h2       = h1;
                h1       = h0;
                h0       = out_idx;
                last_res = out_res;
            end
        end
    end

    // Holds reset low for two edges and clears the bench's own expectations.
    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        up_vld     = 1'b0;
        fu_res_vld = 1'b0;
        resp_hold  = 1'b0;
        repeat (2) @(negedge clk);
        pend.delete();
        exp_q.delete();
        exp_idx = 8'd0;
        rst     = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; presents a triple until the DUT accepts it.
    task automatic push_triple(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        int n;
        up_vld = 1'b1;
        a = x;
        b = y;
        c = z;
        n = 0;
        while (!up_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!up_rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_stall: up_rdy=%0b after %0d cycles, required 1", up_rdy, n);
        end else begin
            pend.push_back({x, y, z});
        end
        @(negedge clk);
        up_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(pend.size() == 0 && exp_q.size() == 0 && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || pend.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: busy=%0b pend=%0d exp=%0d, required all empty",
                     busy, pend.size(), exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        up_vld = 1'b0;
        a = 32'd0;
        b = 32'd0;
        c = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({up_rdy, fu_arg_vld, out_vld, busy, err} !== 5'b0 ||
            {fu_a, fu_b, fu_c, out_res} !== 128'd0 || out_idx !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rdy=%0b arg=%0b ov=%0b busy=%0b err=%0b idx=%0d, required all 0",
                     up_rdy, fu_arg_vld, out_vld, busy, err, out_idx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (up_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: up_rdy=%0b busy=%0b, required 1/0", up_rdy, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int oc;
        do_reset();
        resp_mode  = 0;
        resp_delay = 3;
        oc = out_count;
        up_vld = 1'b1;
        a = 32'd1;
        b = 32'd4;
        c = 32'd9;
        checks++;
        if (up_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_rdy: up_rdy=%0b, required 1", up_rdy);
        end
        pend.push_back({32'd1, 32'd4, 32'd9});
        @(negedge clk);
        up_vld = 1'b0;
        checks++;
        if (fu_arg_vld !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_n1: fu_arg_vld=%0b busy=%0b, required 0/1", fu_arg_vld, busy);
        end
        @(negedge clk);
        checks++;
        if (fu_arg_vld !== 1'b1 || fu_a !== 32'd1 || fu_b !== 32'd4 || fu_c !== 32'd9) begin
            errors++;
            $display("[TB] FAIL single_issue: vld=%0b ops=%0d/%0d/%0d, required 1 with 1/4/9",
                     fu_arg_vld, fu_a, fu_b, fu_c);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early: out_vld=%0b, required 0", out_vld);
        end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1 || out_res !== 32'd6 || out_idx !== 8'd0) begin
            errors++;
            $display("[TB] FAIL single_out: vld=%0b res=%0d idx=%0d, required 1/6/0",
                     out_vld, out_res, out_idx);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || out_vld !== 1'b0 || out_count != oc + 1) begin
            errors++;
            $display("[TB] FAIL single_after: busy=%0b err=%0b out_vld=%0b outs=%0d, required 0/0/0/1",
                     busy, err, out_vld, out_count - oc);
        end
    endtask

    task automatic test_back_to_back();
        int oc;
        bit rdy_seen;
        do_reset();
        resp_mode  = 0;
        resp_delay = 3;
        resp_hold  = 1'b1;
        oc = out_count;
        for (int k = 1; k <= 5; k++) begin
            push_triple(32'(k), 32'(k), 32'(k));
        end
        checks++;
        if (up_rdy !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_full: up_rdy=%0b busy=%0b, required 0/1", up_rdy, busy);
        end
        up_vld = 1'b1;
        a = 32'd6;
        b = 32'd6;
        c = 32'd6;
        rdy_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (up_rdy) rdy_seen = 1'b1;
        end
        checks++;
        if (rdy_seen) begin
            errors++;
            $display("[TB] FAIL bp_held: up_rdy rose while full, required 0");
        end
        resp_hold = 1'b0;
        push_triple(32'd6, 32'd6, 32'd6);
        wait_idle();
        checks++;
        if (out_count != oc + 6 || h0 !== 8'd5 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_total: outs=%0d last_idx=%0d err=%0b, required 6/5/0",
                     out_count - oc, h0, err);
        end
    endtask

    task automatic test_timeout();
        int  oc;
        int  n;
        bit  early_err;
        do_reset();
        resp_mode  = 1;
        resp_delay = 3;
        oc = out_count;
        push_triple(32'd1, 32'd1, 32'd1);
        push_triple(32'd4, 32'd9, 32'd16);
        n = 0;
        while (!fu_arg_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!fu_arg_vld) begin
            errors++;
            $display("[TB] FAIL to_issue: fu_arg_vld=%0b, required 1 within 40 cycles", fu_arg_vld);
        end
        resp_mode = 0;
        early_err = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (err) early_err = 1'b1;
        end
        checks++;
        if (early_err) begin
            errors++;
            $display("[TB] FAIL to_early: err rose before 17 cycles after issue, required 0");
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || fu_arg_vld !== 1'b0 || out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_err: err=%0b arg=%0b out_vld=%0b, required 1/0/0",
                     err, fu_arg_vld, out_vld);
        end
        @(negedge clk);
        checks++;
        if (fu_arg_vld !== 1'b1 || fu_a !== 32'd4) begin
            errors++;
            $display("[TB] FAIL to_next: arg=%0b fu_a=%0d, required 1/4", fu_arg_vld, fu_a);
        end
        wait_idle();
        checks++;
        if (out_count != oc + 1 || h0 !== 8'd0 || last_res !== 32'd9) begin
            errors++;
            $display("[TB] FAIL to_result: outs=%0d idx=%0d res=%0d, required 1/0/9",
                     out_count - oc, h0, last_res);
        end
    endtask

    task automatic test_timeout_edge();
        int oc;
        do_reset();
        resp_mode  = 0;
        resp_delay = 16;
        oc = out_count;
        push_triple(32'd9, 32'd9, 32'd9);
        wait_idle();
        checks++;
        if (err !== 1'b0 || out_count != oc + 1 || last_res !== 32'd9) begin
            errors++;
            $display("[TB] FAIL to_edge: err=%0b outs=%0d res=%0d, required 0/1/9",
                     err, out_count - oc, last_res);
        end
        resp_delay = 3;
    endtask

    task automatic test_stray();
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_pre: err=%0b, required 0", err);
        end
        fu_res_vld = 1'b1;
        fu_res     = 32'd7;
        @(negedge clk);
        fu_res_vld = 1'b0;
        checks++;
        if (err !== 1'b1 || out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_err: err=%0b out_vld=%0b, required 1/0", err, out_vld);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || out_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_after: err=%0b out_vld=%0b busy=%0b, required 1/0/0",
                     err, out_vld, busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        int ic;
        int n;
        bit issued;
        do_reset();
        resp_mode  = 0;
        resp_delay = 3;
        push_triple(32'd16, 32'd25, 32'd36);
        push_triple(32'd49, 32'd64, 32'd81);
        wait_idle();
        checks++;
        if (h0 !== 8'd1 || last_res !== 32'd24) begin
            errors++;
            $display("[TB] FAIL rst_pre: idx=%0d res=%0d, required 1/24", h0, last_res);
        end
        resp_mode = 1;
        ic = issue_count;
        push_triple(32'd1, 32'd1, 32'd1);
        push_triple(32'd2, 32'd2, 32'd2);
        push_triple(32'd3, 32'd3, 32'd3);
        n = 0;
        while (issue_count == ic && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fu_arg_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_wait: busy=%0b arg=%0b, required 1/0", busy, fu_arg_vld);
        end
        rst = 1'b0;
        pend.delete();
        exp_q.delete();
        exp_idx = 8'd0;
        @(negedge clk);
        checks++;
        if ({up_rdy, fu_arg_vld, out_vld, busy, err} !== 5'b0 ||
            {fu_a, fu_b, fu_c, out_res} !== 128'd0 || out_idx !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rst_during: rdy=%0b arg=%0b ov=%0b busy=%0b fu_a=%0d res=%0d idx=%0d, required all 0",
                     up_rdy, fu_arg_vld, out_vld, busy, fu_a, out_res, out_idx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || up_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_after: busy=%0b up_rdy=%0b, required 0/1", busy, up_rdy);
        end
        issued = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (fu_arg_vld) issued = 1'b1;
        end
        checks++;
        if (issued) begin
            errors++;
            $display("[TB] FAIL rst_no_issue: fu_arg_vld seen after reset, required none");
        end
        resp_mode = 0;
        push_triple(32'd100, 32'd100, 32'd100);
        wait_idle();
        checks++;
        if (h0 !== 8'd0 || last_res !== 32'd30) begin
            errors++;
            $display("[TB] FAIL rst_restart: idx=%0d res=%0d, required 0/30", h0, last_res);
        end
    endtask

    task automatic test_index_wrap();
        int oc;
        do_reset();
        resp_mode  = 0;
        resp_delay = 3;
        oc = out_count;
        for (int k = 0; k < 257; k++) begin
            push_triple($urandom, $urandom, $urandom_range(0, 1000));
        end
        wait_idle();
        checks++;
        if (out_count != oc + 257 || h2 !== 8'd254 || h1 !== 8'd255 || h0 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL idx_wrap: outs=%0d tail=%0d,%0d,%0d, required 257 with 254,255,0",
                     out_count - oc, h2, h1, h0);
        end
    endtask

    // Test sequence.
    initial begin
        rst        = 1'b0;
        up_vld     = 1'b0;
        a          = 32'd0;
        b          = 32'd0;
        c          = 32'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_stray();
        test_reset_mid_wait();
        test_index_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
